bus_port_ctrl: RTL and testbench

- Sequencing controller for one end of the shared 8-bit bidirectional data bus.
- In write mode it drives the bus for a fixed hold window, then releases it through a turnaround gap.
- In read mode it leaves the bus at high impedance, waits for the far end to drive, samples the bus and presents the byte on a valid/ready output.
- It sits between a local request interface and the tri-state bus segment, replacing ad-hoc enable wiring with enforced timing.

---
 rtl/bus_port_ctrl.sv | 148 ++++++++++++++
 tb/tb_bus_port_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bus_port_ctrl
// Purpose  : Sequences one end of a shared tri-state bus (timed write drive,
//            turnaround gap, delayed read sample with valid/ready output).
// Revision : 1.0 - initial release
// ============================================================================
module bus_port_ctrl #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int TURN_CYCLES = 1,
  parameter int SAMPLE_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             overrun,
  output logic             busy,
  output logic             bus_oe,
  inout  wire  [WIDTH-1:0] bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam logic [3:0] C_HOLD_LAST   = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] C_TURN_LAST   = 4'((TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0);
  localparam logic [3:0] C_SAMPLE_LAST = 4'(SAMPLE_WAIT - 1);
  localparam bit         C_HAS_TURN    = (TURN_CYCLES > 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [WIDTH-1:0] r_wr_data;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_overrun;
  logic             w_latch;
  logic             w_capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter always restarts at zero on entry to a timed state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    wr_ack      = 1'b0;
    rd_ack      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 4'd0;
        if (wr_req) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_DRIVE;
        end else if (rd_req) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == C_HOLD_LAST) begin
          wr_ack      = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = C_HAS_TURN ? ST_TURN : ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_TURN: begin
        if (r_cnt == C_TURN_LAST) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_WAIT: begin
        if (r_cnt == C_SAMPLE_LAST) begin
          rd_ack      = 1'b1;
          w_capture   = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_cnt_nxt   = 4'd0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_data <= '0;
    end else if (w_latch) begin
      r_wr_data <= wr_data;
    end
  end

  // A capture wins over a same-edge consume; overrun only when the old byte was not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_capture) begin
      r_rd_data  <= bus;
      r_rd_valid <= 1'b1;
      if (r_rd_valid && !rd_ready) begin
        r_overrun <= 1'b1;
      end
    end else if (r_rd_valid && rd_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign overrun  = r_overrun;
  assign busy     = (r_state != ST_IDLE);
  assign bus_oe   = (r_state == ST_DRIVE);
  assign bus      = bus_oe ? r_wr_data : {WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_bus_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_port_ctrl
// Purpose  : Self-checking bench for bus_port_ctrl (default and swept params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_port_ctrl;

  localparam int H0 = 2, T0 = 1, S0 = 1;
  localparam int H1 = 3, T1 = 0, S1 = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  bit         sel;
  logic       wr_req, rd_req, rd_ready, far_oe;
  logic [7:0] wr_data, far_data;

  logic       wr_ack0, rd_ack0, rd_valid0, overrun0, busy0, oe0;
  logic       wr_ack1, rd_ack1, rd_valid1, overrun1, busy1, oe1;
  logic [7:0] rd_data0, rd_data1;
  wire  [7:0] bus0, bus1;

  // far end of each bus segment, only while that instance is selected
  assign bus0 = (far_oe && !sel) ? far_data : 8'bz;
  assign bus1 = (far_oe &&  sel) ? far_data : 8'bz;

  always #5 clk = ~clk;

  bus_port_ctrl #(.WIDTH(8), .HOLD_CYCLES(H0), .TURN_CYCLES(T0), .SAMPLE_WAIT(S0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req && !sel), .wr_data(wr_data), .wr_ack(wr_ack0),
    .rd_req(rd_req && !sel), .rd_ack(rd_ack0), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .rd_ready(rd_ready && !sel), .overrun(overrun0),
    .busy(busy0), .bus_oe(oe0), .bus(bus0)
  );

  bus_port_ctrl #(.WIDTH(8), .HOLD_CYCLES(H1), .TURN_CYCLES(T1), .SAMPLE_WAIT(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req && sel), .wr_data(wr_data), .wr_ack(wr_ack1),
    .rd_req(rd_req && sel), .rd_ack(rd_ack1), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .rd_ready(rd_ready && sel), .overrun(overrun1),
    .busy(busy1), .bus_oe(oe1), .bus(bus1)
  );

  logic       v_oe, v_busy, v_wr_ack, v_rd_ack, v_rd_valid, v_ovr;
  logic [7:0] v_bus, v_rd_data;
  assign v_oe       = sel ? oe1       : oe0;
  assign v_busy     = sel ? busy1     : busy0;
  assign v_wr_ack   = sel ? wr_ack1   : wr_ack0;
  assign v_rd_ack   = sel ? rd_ack1   : rd_ack0;
  assign v_rd_valid = sel ? rd_valid1 : rd_valid0;
  assign v_ovr      = sel ? overrun1  : overrun0;
  assign v_bus      = sel ? bus1      : bus0;
  assign v_rd_data  = sel ? rd_data1  : rd_data0;

  int n_chk = 0;
  int n_err = 0;

  // read-side reference: what a consumer should see, per instance
  logic [7:0] m_data  [2];
  bit         m_valid [2];
  bit         m_ovr   [2];

  function automatic int hold_n();  return sel ? H1 : H0; endfunction
  function automatic int turn_n();  return sel ? T1 : T0; endfunction
  function automatic int swait_n(); return sel ? S1 : S0; endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (dut%0d t=%0t): got %0h, expected %0h", nm, sel, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_data[k] = 8'h00; m_valid[k] = 1'b0; m_ovr[k] = 1'b0;
    end
  endtask

  // Apply the output-register rules for the coming edge, then move to the next negedge.
  task automatic step(input bit cap, input logic [7:0] cd);
    if (cap) begin
      if (m_valid[sel] && !rd_ready) m_ovr[sel] = 1'b1;
      m_data[sel]  = cd;
      m_valid[sel] = 1'b1;
    end else if (m_valid[sel] && rd_ready) begin
      m_valid[sel] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic chk_rd();
    chk("rd_data",  32'(v_rd_data),  32'(m_data[sel]));
    chk("rd_valid", 32'(v_rd_valid), 32'(m_valid[sel]));
    chk("overrun",  32'(v_ovr),      32'(m_ovr[sel]));
  endtask

  task automatic do_write(input logic [7:0] d, input bit rdy);
    chk("wr_start_idle", 32'(v_busy), 0);
    wr_req = 1'b1; wr_data = d; rd_ready = rdy;
    for (int i = 1; i <= hold_n(); i++) begin
      step(1'b0, 8'h00);
      chk("wr_oe",      32'(v_oe),     1);
      chk("wr_bus",     32'(v_bus),    32'(d));
      chk("wr_ack",     32'(v_wr_ack), 32'(i == hold_n()));
      chk("wr_no_rdack", 32'(v_rd_ack), 0);
      if (i == hold_n()) wr_req = 1'b0;
    end
    for (int j = 1; j <= turn_n(); j++) begin
      step(1'b0, 8'h00);
      chk("turn_oe",   32'(v_oe),     0);
      chk("turn_busy", 32'(v_busy),   1);
      chk("turn_ack",  32'(v_wr_ack), 0);
    end
    step(1'b0, 8'h00);
    chk("wr_end_busy", 32'(v_busy), 0);
    chk("wr_end_oe",   32'(v_oe),   0);
    rd_ready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] d, input bit rdy);
    chk("rd_start_idle", 32'(v_busy), 0);
    far_data = d; far_oe = 1'b1; rd_req = 1'b1; rd_ready = 1'b0;
    for (int i = 1; i <= swait_n(); i++) begin
      step(1'b0, 8'h00);
      chk("wait_oe",    32'(v_oe),     0);
      chk("wait_busy",  32'(v_busy),   1);
      chk("rd_ack",     32'(v_rd_ack), 32'(i == swait_n()));
      chk("wait_wrack", 32'(v_wr_ack), 0);
      if (i == swait_n()) begin
        rd_req = 1'b0; rd_ready = rdy;
      end
    end
    step(1'b1, d);
    rd_ready = 1'b0; far_oe = 1'b0;
    chk("rd_end_busy", 32'(v_busy),   0);
    chk("rd_end_ack",  32'(v_rd_ack), 0);
    chk_rd();
  endtask

  task automatic do_pop();
    rd_ready = 1'b1;
    step(1'b0, 8'h00);
    rd_ready = 1'b0;
    chk_rd();
  endtask

  typedef enum int {OP_WR, OP_RD, OP_POP} op_e;
  typedef struct {
    op_e        op;
    int         s;
    logic [7:0] d;
    bit         rdy;
    logic [7:0] e_data;
    bit         e_valid;
    bit         e_ovr;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{OP_WR,  0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{OP_RD,  0, 8'h3C, 1'b0, 8'h3C, 1'b1, 1'b0};
    tbl[2]  = '{OP_WR,  0, 8'h5A, 1'b0, 8'h3C, 1'b1, 1'b0};
    tbl[3]  = '{OP_POP, 0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[4]  = '{OP_RD,  0, 8'h01, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[5]  = '{OP_RD,  0, 8'h02, 1'b0, 8'h02, 1'b1, 1'b1};
    tbl[6]  = '{OP_POP, 0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1};
    tbl[7]  = '{OP_RD,  1, 8'h01, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[8]  = '{OP_RD,  1, 8'h02, 1'b1, 8'h02, 1'b1, 1'b0};
    tbl[9]  = '{OP_POP, 1, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0};
    tbl[10] = '{OP_WR,  1, 8'h5A, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[11] = '{OP_WR,  1, 8'hC3, 1'b1, 8'h02, 1'b0, 1'b0};

    rst_n = 1'b0; sel = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0; rd_ready = 1'b0; far_oe = 1'b0;
    wr_data = 8'h00; far_data = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);

    chk("rst_oe0",    32'(oe0),       0);
    chk("rst_busy0",  32'(busy0),     0);
    chk("rst_valid0", 32'(rd_valid0), 0);
    chk("rst_data0",  32'(rd_data0),  0);
    chk("rst_ovr0",   32'(overrun0),  0);
    chk("rst_oe1",    32'(oe1),       0);
    chk("rst_busy1",  32'(busy1),     0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      sel = (tbl[i].s != 0);
      case (tbl[i].op)
        OP_WR:   do_write(tbl[i].d, tbl[i].rdy);
        OP_RD:   do_read(tbl[i].d, tbl[i].rdy);
        default: do_pop();
      endcase
      chk("tbl_data",  32'(v_rd_data),  32'(tbl[i].e_data));
      chk("tbl_valid", 32'(v_rd_valid), 32'(tbl[i].e_valid));
      chk("tbl_ovr",   32'(v_ovr),      32'(tbl[i].e_ovr));
    end

    // both requests together: write first, held read follows
    sel = 1'b0;
    rd_req = 1'b1;
    do_write(8'h11, 1'b0);
    do_read(8'h77, 1'b0);
    chk("simul_data", 32'(rd_data0), 32'h77);

    // reset in the second drive cycle: outputs drop without an edge
    sel = 1'b0;
    wr_req = 1'b1; wr_data = 8'h5A;
    step(1'b0, 8'h00);
    chk("rstw_oe_c1",  32'(oe0),     1);
    chk("rstw_ack_c1", 32'(wr_ack0), 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_oe",    32'(oe0),       0);
    chk("rstw_ack",   32'(wr_ack0),   0);
    chk("rstw_busy",  32'(busy0),     0);
    chk("rstw_valid", 32'(rd_valid0), 0);
    chk("rstw_data",  32'(rd_data0),  0);
    chk("rstw_ovr",   32'(overrun0),  0);
    chk("rstw_data1", 32'(rd_data1),  0);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("rstw_hold_ack", 32'(wr_ack0), 0);
      chk("rstw_hold_oe",  32'(oe0),     0);
    end
    wr_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstw_after_busy", 32'(busy0), 0);

    for (int t = 0; t < 80; t++) begin
      int         op;
      logic [7:0] d;
      bit         r;
      sel = 1'($urandom_range(0, 1));
      op  = int'($urandom_range(0, 4));
      d   = 8'($urandom);
      r   = 1'($urandom_range(0, 1));
      case (op)
        0, 1: do_write(d, r);
        2, 3: do_read(d, r);
        default: do_pop();
      endcase
      chk_rd();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
